// File: rtl/uart_tx_arb_pkg.sv
// uart_tx_arb_pkg: shared state encoding, requester count and round-robin helper
package uart_tx_arb_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    STROBE   = 2'b01,
    WAITBUSY = 2'b10,
    WAITDONE = 2'b11
  } state_e;
  localparam int NREQ = 3;
  localparam logic [1:0] NO_OWNER = 2'd3;
  function automatic logic [1:0] rr_next(input logic [1:0] i);
    return (i >= 2'd2) ? 2'd0 : i + 2'd1;
  endfunction
endpackage

// File: rtl/uart_tx_arb_rr_pick3.sv
// rr_pick3: three-way round-robin pick, searching upward from one above ptr
module rr_pick3
  import uart_tx_arb_pkg::*;
(
  input  logic [NREQ-1:0] elig,
  input  logic [1:0]      ptr,
  output logic [1:0]      gnt,
  output logic            vld
);
  logic [1:0] c0, c1, c2;
  always_comb begin
    c0 = rr_next(ptr);
    c1 = rr_next(c0);
    c2 = rr_next(c1);
    gnt = elig[c0] ? c0 : elig[c1] ? c1 : c2;
    vld = |elig;
  end
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: arbitrates three byte sources onto one UART transmitter,
// locking a multi-byte message to its owner until its last byte is accepted.
module uart_tx_arb
  import uart_tx_arb_pkg::*;
#(
  parameter int BUSY_WAIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic [7:0]      data0,
  input  logic [7:0]      data1,
  input  logic [7:0]      data2,
  input  logic [NREQ-1:0] last,
  output logic [NREQ-1:0] ack,
  input  logic            txBusy,
  output logic [7:0]      utb_txdata,
  output logic            utb_txdata_rdy,
  output logic [1:0]      owner,
  output logic            active
);
  localparam int CW = BUSY_WAIT > 0 ? $clog2(BUSY_WAIT + 1) : 1;
  localparam logic [CW-1:0] LIMIT = CW'(BUSY_WAIT > 0 ? BUSY_WAIT - 1 : 0);
  localparam logic [CW-1:0] CMAX = '1;
  state_e          state_q, state_d;
  logic [7:0]      data_q, data_d, sel_data;
  logic [1:0]      owner_q, owner_d, ptr_q, ptr_d, gnt;
  logic            active_q, active_d, vld, take, sel_last;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] elig;
  assign elig = active_q ? (req & (NREQ'(1) << owner_q)) : req;
  rr_pick3 u_rr (
    .elig(elig),
    .ptr (ptr_q),
    .gnt (gnt),
    .vld (vld)
  );
  always_comb begin
    sel_data = gnt == 2'd0 ? data0 : gnt == 2'd1 ? data1 : data2;
    sel_last = last[gnt];
    take = state_q == IDLE && !txBusy && vld;
    // ack is combinational, so it must also be masked while reset is held
    ack = take && rst ? NREQ'(1) << gnt : '0;
    state_d = state_q;
    data_d = data_q;
    owner_d = owner_q;
    active_d = active_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          data_d = sel_data;
          state_d = STROBE;
          active_d = !sel_last;
          owner_d = sel_last ? NO_OWNER : gnt;
          ptr_d = sel_last ? gnt : ptr_q;
        end
      end
      STROBE: begin
        cnt_d = '0;
        state_d = BUSY_WAIT == 0 ? IDLE : WAITBUSY;
      end
      WAITBUSY: begin
        cnt_d = cnt_q == CMAX ? cnt_q : cnt_q + 1'b1;
        state_d = txBusy ? WAITDONE : cnt_q == LIMIT ? IDLE : WAITBUSY;
      end
      default: state_d = txBusy ? WAITDONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      data_q <= 8'h00;
      owner_q <= NO_OWNER;
      active_q <= 1'b0;
      ptr_q <= 2'd2;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      owner_q <= owner_d;
      active_q <= active_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
  assign utb_txdata = data_q;
  assign utb_txdata_rdy = state_q == STROBE;
  assign owner = owner_q;
  assign active = active_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scenario tasks plus a randomized run checked against a
// message-level round-robin model of the arbiter.
module tb_uart_tx_arb;
  logic clk = 0, rst = 0, txBusy = 0, utb_txdata_rdy, active;
  logic [2:0] req = 0, last = 0, ack;
  logic [7:0] data0 = 0, data1 = 0, data2 = 0, utb_txdata;
  logic [1:0] owner;
  uart_tx_arb #(.BUSY_WAIT(4)) dut (
    .clk(clk), .rst(rst), .req(req), .data0(data0), .data1(data1), .data2(data2),
    .last(last), .ack(ack), .txBusy(txBusy), .utb_txdata(utb_txdata),
    .utb_txdata_rdy(utb_txdata_rdy), .owner(owner), .active(active)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, bs = 0, be = 0, busy_dly = 1, busy_len = 2, bad = 0, model_ptr = 2;
  bit force_busy = 0;
  logic [8:0] q0[$], q1[$], q2[$];
  int ack_who[$], ack_cyc[$], sc[$], ew[$];
  logic [7:0] sb[$], eb[$];
  logic [2:0] sao[$];
  bit el[$];
  task automatic clear_rec();
    ack_who.delete(); ack_cyc.delete(); sc.delete(); sb.delete(); sao.delete(); bad = 0;
  endtask
  task automatic push(int i, logic [8:0] v);
    if (i == 0) q0.push_back(v); else if (i == 1) q1.push_back(v); else q2.push_back(v);
  endtask
  // One cycle: drive requesters and the UART busy model at negedge, then observe.
  task automatic step();
    int w;
    @(negedge clk);
    cyc++;
    txBusy = force_busy || (cyc >= bs && cyc < be);
    req = {q2.size() > 0, q1.size() > 0, q0.size() > 0};
    data0 = q0.size() > 0 ? q0[0][7:0] : 8'h00;
    data1 = q1.size() > 0 ? q1[0][7:0] : 8'h00;
    data2 = q2.size() > 0 ? q2[0][7:0] : 8'h00;
    last = {q2.size() > 0 && q2[0][8], q1.size() > 0 && q1[0][8], q0.size() > 0 && q0[0][8]};
    #1;
    if (ack != 3'b000) begin
      if ($countones(ack) != 1 || txBusy || (ack & req) != ack) bad++;
      w = ack[0] ? 0 : ack[1] ? 1 : 2;
      ack_who.push_back(w);
      ack_cyc.push_back(cyc);
      if (w == 0) void'(q0.pop_front()); else if (w == 1) void'(q1.pop_front()); else void'(q2.pop_front());
    end
    if (utb_txdata_rdy) begin
      if (ack_cyc.size() == 0 || ack_cyc[ack_cyc.size()-1] != cyc - 1) bad++;
      sb.push_back(utb_txdata);
      sc.push_back(cyc);
      sao.push_back({active, owner});
      if (busy_dly >= 0) begin
        bs = cyc + busy_dly;
        be = bs + busy_len;
      end
    end
  endtask
  task automatic drain(output bit to);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && n < 3000) begin
      step();
      n++;
    end
    repeat (25) step();
    to = n >= 3000;
  endtask
  // Whole messages leave in round-robin order starting one above the last finisher.
  task automatic build_expected();
    logic [8:0] k0[$], k1[$], k2[$];
    logic [8:0] b;
    int p, i;
    k0 = q0; k1 = q1; k2 = q2;
    p = model_ptr;
    eb.delete(); ew.delete(); el.delete();
    while (k0.size() + k1.size() + k2.size() > 0) begin
      i = p;
      for (int s = 1; s <= 3; s++) begin
        i = (p + s) % 3;
        if ((i == 0 ? k0.size() : i == 1 ? k1.size() : k2.size()) > 0) break;
      end
      do begin
        if (i == 0) b = k0.pop_front(); else if (i == 1) b = k1.pop_front(); else b = k2.pop_front();
        eb.push_back(b[7:0]); ew.push_back(i); el.push_back(b[8]);
      end while (!b[8]);
      p = i;
    end
    model_ptr = p;
  endtask
  task automatic test_reset();
    q0.push_back({1'b1, 8'h99});
    step(); step();
    n_chk++; if (ack !== 3'b000) begin n_fail++; $display("FAIL reset_ack: got %b expected 000", ack); end
    n_chk++; if (utb_txdata_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy: got %b expected 0", utb_txdata_rdy); end
    n_chk++; if (utb_txdata !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h expected 00", utb_txdata); end
    n_chk++; if (owner !== 2'd3) begin n_fail++; $display("FAIL reset_owner: got %0d expected 3", owner); end
    n_chk++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
    q0.delete();
    step();
    rst = 1;
  endtask
  task automatic test_round_robin();
    int exp_w[4] = '{0, 1, 2, 0};
    bit to;
    busy_dly = 1; busy_len = 2;
    q0.push_back({1'b1, 8'h10}); q1.push_back({1'b1, 8'h11});
    q2.push_back({1'b1, 8'h12}); q0.push_back({1'b1, 8'h13});
    clear_rec();
    drain(to);
    n_chk++; if (to || ack_who.size() != 4 || bad != 0) begin n_fail++; $display("FAIL rr_count: got %0d acks, %0d violations, timeout %0d expected 4,0,0", ack_who.size(), bad, to); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (ack_who[k] != exp_w[k] || sb[k] !== 8'(8'h10 + k) || sao[k] !== 3'b011) begin
        n_fail++; $display("FAIL rr_grant%0d: got req %0d byte %h ao %b expected req %0d byte %h ao 011", k, ack_who[k], sb[k], sao[k], exp_w[k], 8'(8'h10 + k));
      end
    end
  endtask
  task automatic test_single_byte();
    bit to;
    busy_dly = 1; busy_len = 10;
    q0.push_back({1'b1, 8'h41});
    clear_rec();
    drain(to);
    n_chk++; if (to || ack_who.size() != 1 || ack_who[0] != 0) begin n_fail++; $display("FAIL single_ack: got %0d acks first req %0d expected 1 ack req 0", ack_who.size(), ack_who[0]); end
    n_chk++; if (sc.size() != 1 || sc[0] != ack_cyc[0] + 1 || sb[0] !== 8'h41) begin n_fail++; $display("FAIL single_strobe: got cyc %0d byte %h expected cyc %0d byte 41", sc[0], sb[0], ack_cyc[0] + 1); end
    n_chk++; if (sao[0] !== 3'b011 || active !== 1'b0 || bad != 0) begin n_fail++; $display("FAIL single_active: got ao %b active %b violations %0d expected 011 0 0", sao[0], active, bad); end
  endtask
  task automatic test_lock();
    int exp_w[4] = '{1, 1, 1, 0};
    logic [7:0] exp_b[4] = '{8'h41, 8'h42, 8'h0D, 8'h30};
    logic [2:0] exp_ao[4] = '{3'b101, 3'b101, 3'b011, 3'b011};
    bit to;
    busy_dly = 1; busy_len = 3;
    q1.push_back({1'b0, 8'h41}); q1.push_back({1'b0, 8'h42}); q1.push_back({1'b1, 8'h0D});
    q0.push_back({1'b1, 8'h30});
    clear_rec();
    drain(to);
    n_chk++; if (to || ack_who.size() != 4 || bad != 0) begin n_fail++; $display("FAIL lock_count: got %0d acks, %0d violations expected 4,0", ack_who.size(), bad); end
    for (int k = 0; k < 4; k++) begin
      n_chk++; if (ack_who[k] != exp_w[k] || sb[k] !== exp_b[k] || sao[k] !== exp_ao[k]) begin
        n_fail++; $display("FAIL lock_byte%0d: got req %0d byte %h ao %b expected req %0d byte %h ao %b", k, ack_who[k], sb[k], sao[k], exp_w[k], exp_b[k], exp_ao[k]);
      end
    end
  endtask
  task automatic test_timeout();
    bit to;
    busy_dly = -1;
    q2.push_back({1'b1, 8'h55}); q2.push_back({1'b1, 8'h66});
    clear_rec();
    drain(to);
    n_chk++; if (to || sc.size() != 2 || sb[0] !== 8'h55 || sb[1] !== 8'h66) begin n_fail++; $display("FAIL timeout_bytes: got %0d strobes %h %h expected 2 strobes 55 66", sc.size(), sb[0], sb[1]); end
    n_chk++; if (sc[1] - sc[0] != 6 || ack_cyc[1] - sc[0] != 5) begin n_fail++; $display("FAIL timeout_gap: got strobe gap %0d ack gap %0d expected 6 5", sc[1] - sc[0], ack_cyc[1] - sc[0]); end
  endtask
  task automatic test_busy_hold();
    int rel;
    bit to;
    busy_dly = 1; busy_len = 2;
    force_busy = 1;
    q2.push_back({1'b1, 8'h7E});
    clear_rec();
    repeat (6) step();
    n_chk++; if (ack_who.size() != 0 || sc.size() != 0) begin n_fail++; $display("FAIL busy_hold: got %0d acks %0d strobes expected 0 0", ack_who.size(), sc.size()); end
    force_busy = 0;
    rel = cyc;
    drain(to);
    n_chk++; if (to || ack_who.size() != 1 || ack_who[0] != 2 || sb[0] !== 8'h7E || ack_cyc[0] <= rel) begin
      n_fail++; $display("FAIL busy_release: got %0d acks req %0d byte %h at %0d expected 1 ack req 2 byte 7e after %0d", ack_who.size(), ack_who[0], sb[0], ack_cyc[0], rel);
    end
  endtask
  task automatic test_reset_mid();
    int n = 0, rel;
    bit to;
    busy_dly = 1; busy_len = 30;
    q2.push_back({1'b0, 8'hA1}); q2.push_back({1'b0, 8'hA2}); q2.push_back({1'b1, 8'hA3});
    clear_rec();
    while (sc.size() == 0 && n < 50) begin step(); n++; end
    repeat (3) step();
    n_chk++; if (active !== 1'b1 || owner !== 2'd2) begin n_fail++; $display("FAIL mid_locked: got active %b owner %0d expected 1 2", active, owner); end
    @(negedge clk);
    rst = 0;
    txBusy = 0;
    #1;
    n_chk++; if (ack !== 3'b000 || utb_txdata_rdy !== 1'b0 || utb_txdata !== 8'h00) begin n_fail++; $display("FAIL mid_reset_out: got ack %b rdy %b data %h expected 000 0 00", ack, utb_txdata_rdy, utb_txdata); end
    n_chk++; if (owner !== 2'd3 || active !== 1'b0) begin n_fail++; $display("FAIL mid_reset_lock: got owner %0d active %b expected 3 0", owner, active); end
    q2.delete();
    bs = 0; be = 0;
    busy_len = 3;
    clear_rec();
    step(); step();
    rst = 1;
    rel = cyc;
    q0.push_back({1'b1, 8'hC0}); q1.push_back({1'b1, 8'hC1});
    drain(to);
    n_chk++; if (to || ack_who.size() != 2 || ack_who[0] != 0 || ack_who[1] != 1) begin n_fail++; $display("FAIL mid_order: got %0d acks first %0d second %0d expected 2 acks 0 then 1", ack_who.size(), ack_who[0], ack_who[1]); end
    n_chk++; if (sb[0] !== 8'hC0 || sc[0] <= rel + 1 || bad != 0) begin n_fail++; $display("FAIL mid_strobe: got byte %h at %0d violations %0d expected c0 after %0d", sb[0], sc[0], bad, rel + 1); end
    model_ptr = 1;
  endtask
  task automatic test_random();
    bit to;
    logic [2:0] exp_ao;
    for (int r = 0; r < 8; r++) begin
      busy_dly = int'($urandom_range(0, 4)) - 1;
      busy_len = int'($urandom_range(1, 4));
      for (int i = 0; i < 3; i++)
        for (int m = int'($urandom_range(0, 2)); m > 0; m--)
          for (int b = int'($urandom_range(1, 3)); b > 0; b--)
            push(i, {b == 1, 8'($urandom)});
      build_expected();
      clear_rec();
      drain(to);
      n_chk++; if (to || ack_who.size() != ew.size() || sb.size() != eb.size() || bad != 0) begin
        n_fail++; $display("FAIL rand%0d_count: got %0d acks %0d strobes %0d violations expected %0d %0d 0", r, ack_who.size(), sb.size(), bad, ew.size(), eb.size());
      end
      for (int k = 0; k < eb.size(); k++) begin
        exp_ao = el[k] ? 3'b011 : {1'b1, 2'(ew[k])};
        n_chk++; if (ack_who[k] != ew[k] || sb[k] !== eb[k] || sao[k] !== exp_ao) begin
          n_fail++; $display("FAIL rand%0d_byte%0d: got req %0d byte %h ao %b expected req %0d byte %h ao %b", r, k, ack_who[k], sb[k], sao[k], ew[k], eb[k], exp_ao);
        end
      end
    end
  endtask
  initial begin
    test_reset();
    test_round_robin();
    test_single_byte();
    test_lock();
    test_timeout();
    test_busy_hold();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within 50000 cycles");
    $fatal(1);
  end
endmodule
